// File: rtl/preadder_stage.sv
// preadder_stage: A/B/D input pipelines, INMODE register and the 25-bit D+/-A
// pre-adder that produce the multiplier operands AMULT and BMULT.
module preadder_stage #(
    parameter int AREG      = 1,
    parameter int BREG      = 1,
    parameter int DREG      = 1,
    parameter int ADREG     = 1,
    parameter int INMODEREG = 1,
    parameter int USE_DPORT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CEA1,
    input  logic               CEA2,
    input  logic               CEB1,
    input  logic               CEB2,
    input  logic               CED,
    input  logic               CEAD,
    input  logic               CEINMODE,
    input  logic        [29:0] A,
    input  logic signed [17:0] B,
    input  logic signed [24:0] D,
    input  logic        [4:0]  INMODE,
    output logic signed [24:0] AMULT,
    output logic signed [17:0] BMULT
);

    // Wrapping 25-bit pre-adder: no saturation, overflow simply wraps.
    function automatic logic signed [24:0] pre_add(input logic sub,
                                                   input logic signed [24:0] d_op,
                                                   input logic signed [24:0] a_op);
        return sub ? (d_op - a_op) : (d_op + a_op);
    endfunction

    logic signed [24:0] a_in;
    logic signed [24:0] a_p1;
    logic signed [24:0] a_p2;
    logic signed [17:0] b_p1;
    logic signed [17:0] b_p2;
    logic        [4:0]  im;
    logic signed [24:0] a_op;

    // Only A[24:0] is an operand; the upper bits and any enables that a given
    // configuration bypasses are intentionally left without a load.
    logic unused_sink;
    assign unused_sink = ^{clk, rst, A[29:25], D, CEA1, CEA2, CEB1, CEB2,
                           CED, CEAD, CEINMODE, im[3:2]};

    assign a_in = A[24:0];

    // ---- A pipeline: A -> A1 -> A2 ----
    if (AREG == 2) begin : g_areg2
        // Two-deep A pipeline, each stage with its own enable
        always_ff @(posedge clk) begin
            if (rst) begin
                a_p1 <= '0;
                a_p2 <= '0;
            end else begin
                if (CEA1) a_p1 <= a_in;
                if (CEA2) a_p2 <= a_p1;
            end
        end
    end else if (AREG == 1) begin : g_areg1
        // Single A register; A1 aliases A2
        always_ff @(posedge clk) begin
            if (rst)       a_p2 <= '0;
            else if (CEA2) a_p2 <= a_in;
        end
        assign a_p1 = a_p2;
    end else begin : g_areg0
        assign a_p1 = a_in;
        assign a_p2 = a_in;
    end

    // ---- B pipeline: B -> B1 -> B2 ----
    if (BREG == 2) begin : g_breg2
        // Two-deep B pipeline, each stage with its own enable
        always_ff @(posedge clk) begin
            if (rst) begin
                b_p1 <= '0;
                b_p2 <= '0;
            end else begin
                if (CEB1) b_p1 <= B;
                if (CEB2) b_p2 <= b_p1;
            end
        end
    end else if (BREG == 1) begin : g_breg1
        // Single B register; B1 aliases B2
        always_ff @(posedge clk) begin
            if (rst)       b_p2 <= '0;
            else if (CEB2) b_p2 <= B;
        end
        assign b_p1 = b_p2;
    end else begin : g_breg0
        assign b_p1 = B;
        assign b_p2 = B;
    end

    // ---- INMODE control ----
    if (INMODEREG == 1) begin : g_imreg
        // INMODE register, delays control changes by one cycle
        always_ff @(posedge clk) begin
            if (rst)           im <= '0;
            else if (CEINMODE) im <= INMODE;
        end
    end else begin : g_imcomb
        assign im = INMODE;
    end

    // ---- Operand selection ----
    assign a_op  = im[1] ? '0 : (im[0] ? a_p1 : a_p2);
    assign BMULT = im[4] ? b_p1 : b_p2;

    // ---- D register, pre-adder and AD register ----
    if (USE_DPORT == 1) begin : g_dport
        logic signed [24:0] d_p1;
        logic signed [24:0] d_op;
        logic signed [24:0] ad;

        if (DREG == 1) begin : g_dreg
            // D input register
            always_ff @(posedge clk) begin
                if (rst)      d_p1 <= '0;
                else if (CED) d_p1 <= D;
            end
        end else begin : g_dcomb
            assign d_p1 = D;
        end

        assign d_op = im[2] ? d_p1 : '0;
        assign ad   = pre_add(im[3], d_op, a_op);

        if (ADREG == 1) begin : g_adreg
            logic signed [24:0] ad_p1;
            // Pre-adder output register feeding the multiplier
            always_ff @(posedge clk) begin
                if (rst)       ad_p1 <= '0;
                else if (CEAD) ad_p1 <= ad;
            end
            assign AMULT = ad_p1;
        end else begin : g_adcomb
            assign AMULT = ad;
        end
    end else begin : g_nodport
        // Pre-adder bypassed: the selected A operand goes straight through
        assign AMULT = a_op;
    end

endmodule

// File: tb/tb_preadder_stage.sv
// Testbench for preadder_stage: two instances (pre-adder path and a
// deep-pipeline bypass path) with a cycle-tagged expected-value scoreboard.
module tb_preadder_stage;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  // Instance 0: USE_DPORT=1, AREG=BREG=DREG=ADREG=INMODEREG=1
  logic        [29:0] a0;
  logic signed [17:0] b0;
  logic signed [24:0] d0;
  logic        [4:0]  im0;
  logic        [6:0]  ce0;
  logic signed [24:0] am0;
  logic signed [17:0] bm0;

  // Instance 1: USE_DPORT=0, AREG=BREG=2, INMODE combinational
  logic        [29:0] a1;
  logic signed [17:0] b1;
  logic signed [24:0] d1;
  logic        [4:0]  im1;
  logic        [6:0]  ce1;
  logic signed [24:0] am1;
  logic signed [17:0] bm1;

  // ce bit map: 0 CEA1, 1 CEA2, 2 CEB1, 3 CEB2, 4 CED, 5 CEAD, 6 CEINMODE
  preadder_stage #(
    .AREG(1), .BREG(1), .DREG(1), .ADREG(1), .INMODEREG(1), .USE_DPORT(1)
  ) u0 (
    .clk(clk), .rst(rst),
    .CEA1(ce0[0]), .CEA2(ce0[1]), .CEB1(ce0[2]), .CEB2(ce0[3]),
    .CED(ce0[4]), .CEAD(ce0[5]), .CEINMODE(ce0[6]),
    .A(a0), .B(b0), .D(d0), .INMODE(im0),
    .AMULT(am0), .BMULT(bm0)
  );

  preadder_stage #(
    .AREG(2), .BREG(2), .DREG(1), .ADREG(1), .INMODEREG(0), .USE_DPORT(0)
  ) u1 (
    .clk(clk), .rst(rst),
    .CEA1(ce1[0]), .CEA2(ce1[1]), .CEB1(ce1[2]), .CEB2(ce1[3]),
    .CED(ce1[4]), .CEAD(ce1[5]), .CEINMODE(ce1[6]),
    .A(a1), .B(b1), .D(d1), .INMODE(im1),
    .AMULT(am1), .BMULT(bm1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          dut;
    int          port;
    logic [24:0] val;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [24:0] act;

  // Queue an expected output value 'lat' rising edges from now.
  function automatic void expect_out(int dut, int port, int lat, int v, int tag);
    exp_t e;
    e.at   = cyc + lat;
    e.dut  = dut;
    e.port = port;
    e.val  = 25'(v);
    e.tag  = tag;
    sb.push_back(e);
  endfunction

  function automatic logic [24:0] sample(int dut, int port);
    if (dut == 0) return (port == 0) ? am0 : {{7{bm0[17]}}, bm0};
    return (port == 0) ? am1 : {{7{bm1[17]}}, bm1};
  endfunction

  // Monitor: on each falling edge compare every entry due this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        act = sample(sb[i].dut, sb[i].port);
        n_cmp++;
        if (sb[i].at < cyc || act !== sb[i].val) begin
          n_bad++;
          $display("FAIL tag%0d u%0d.%s cyc%0d: got %0d (0x%h) expected %0d (0x%h)",
                   sb[i].tag, sb[i].dut, (sb[i].port == 0) ? "AMULT" : "BMULT",
                   cyc, $signed(act), act, $signed(sb[i].val), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every enable low must still clear all registers
    rst = 1'b1; ce0 = '0; ce1 = '0;
    a0 = 30'd55; b0 = 18'sd7; d0 = 25'sd9; im0 = 5'b00100;
    a1 = 30'd55; b1 = 18'sd7; d1 = 25'sd9; im1 = 5'b00000;
    expect_out(0, 0, 1, 0, 1);
    expect_out(0, 1, 1, 0, 2);
    expect_out(1, 0, 1, 0, 3);
    expect_out(1, 1, 1, 0, 4);
    step(); step();

    n_cmp++;
    if (am0 !== 25'sd0) begin
      n_bad++;
      $display("FAIL reset u0.AMULT: got %0d expected 0", am0);
    end
    n_cmp++;
    if (bm0 !== 18'sd0) begin
      n_bad++;
      $display("FAIL reset u0.BMULT: got %0d expected 0", bm0);
    end
    n_cmp++;
    if (am1 !== 25'sd0) begin
      n_bad++;
      $display("FAIL reset u1.AMULT: got %0d expected 0", am1);
    end
    n_cmp++;
    if (bm1 !== 18'sd0) begin
      n_bad++;
      $display("FAIL reset u1.BMULT: got %0d expected 0", bm1);
    end

    // Pre-adder: D+A, D-A, wrap, zero-A, -A
    rst = 1'b0; ce0 = 7'h7F;
    a0 = 30'd7; d0 = 25'sd3; im0 = 5'b00100; b0 = 18'sd11;
    expect_out(0, 0, 2, 10, 10);
    expect_out(0, 1, 1, 11, 11);
    step();
    im0 = 5'b01100;
    expect_out(0, 0, 2, -4, 12);
    step();
    d0 = 25'h0FFFFFF; a0 = 30'd1; im0 = 5'b00100;
    expect_out(0, 0, 2, 25'h1000000, 13);
    step();
    d0 = 25'sd5; a0 = 30'd100; im0 = 5'b00110;
    expect_out(0, 0, 2, 5, 14);
    step();
    d0 = 25'sd77; a0 = 30'd20; im0 = 5'b01000;
    expect_out(0, 0, 2, -20, 15);
    step();

    // CEAD freeze holds AMULT while upstream keeps loading
    a0 = 30'd7; d0 = 25'sd3; im0 = 5'b00100;
    step(); step();
    expect_out(0, 0, 0, 10, 16);
    ce0[5] = 1'b0; a0 = 30'd1;
    expect_out(0, 0, 2, 10, 17);
    step(); step();
    ce0[5] = 1'b1;
    expect_out(0, 0, 1, 4, 18);
    step();

    // Reset mid-stream, then full latency before first valid operand
    a0 = 30'd7;
    step(); step();
    expect_out(0, 0, 0, 10, 19);
    rst = 1'b1;
    expect_out(0, 0, 1, 0, 20);
    expect_out(0, 1, 1, 0, 21);
    step();
    rst = 1'b0;
    expect_out(0, 0, 1, 0, 22);
    expect_out(0, 0, 2, 10, 23);
    expect_out(0, 1, 1, 11, 24);
    step(); step(); step();

    // AREG=2: A2 frozen at 5 while A1 streams 9
    ce1 = 7'h7F; a1 = 30'd5; im1 = 5'b00000;
    expect_out(1, 0, 2, 5, 30);
    step(); step();
    ce1[1] = 1'b0; a1 = 30'd9;
    step();
    im1 = 5'b00000;
    expect_out(1, 0, 0, 5, 31);
    step();
    im1 = 5'b00001;
    expect_out(1, 0, 0, 9, 32);
    step();
    im1 = 5'b00011;
    expect_out(1, 0, 0, 0, 33);
    step();

    // USE_DPORT=0: IM[1] zeroes A; D, IM[2], IM[3] have no effect
    ce1[1] = 1'b1; a1 = 30'd123; d1 = 25'h1555555; im1 = 5'b00010;
    expect_out(1, 0, 0, 0, 34);
    step();
    d1 = 25'h0AAAAAA;
    step();
    im1 = 5'b00000;
    expect_out(1, 0, 0, 123, 35);
    step();
    d1 = -25'sd1; im1 = 5'b00100;
    expect_out(1, 0, 0, 123, 36);
    step();
    d1 = 25'sd0; im1 = 5'b01100;
    expect_out(1, 0, 0, 123, 37);
    step();

    // BREG=2: lag 2 via B2, lag 1 via B1
    im1 = 5'b00000;
    b1 = 18'sd1; expect_out(1, 1, 2, 1, 40); step();
    b1 = 18'sd2; expect_out(1, 1, 2, 2, 41); step();
    b1 = 18'sd3; expect_out(1, 1, 2, 3, 42); step();
    step(); step();
    im1 = 5'b10000;
    b1 = 18'sd4;  expect_out(1, 1, 1, 4, 43);  step();
    b1 = 18'sd5;  expect_out(1, 1, 1, 5, 44);  step();
    b1 = -18'sd2; expect_out(1, 1, 1, -2, 45); step();
    step(); step();

    // Anything still queued was never checked
    foreach (sb[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tag%0d u%0d: expected value due at cyc%0d never compared (now cyc%0d)",
               sb[i].tag, sb[i].dut, sb[i].at, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
